// File: rtl/count_capture_pkg.sv
// count_capture_pkg
// Shared widths, constants and the FIFO entry type for the count capture
// slice. Every file in the slice imports this package.
//
// Optional build macro: COUNT_CAPTURE_TS_EN adds a 16-bit timestamp field
// to each captured entry.
package count_capture_pkg;

  localparam int DATA_W  = 8;
  localparam int EPOCH_W = 4;
  localparam int TS_W    = 16;

  // Top of the monitored counter range; a step between MAX_COUNT and zero
  // is treated as a wrap-around.
  localparam logic [DATA_W-1:0] MAX_COUNT = '1;

  // One FIFO snapshot: signed wrap epoch plus the raw counter value.
  typedef struct packed {
    logic signed [EPOCH_W-1:0] epoch;
    logic [DATA_W-1:0]         count;
`ifdef COUNT_CAPTURE_TS_EN
    logic [TS_W-1:0]           ts;
`else
    // No timestamp field in the default build.
`endif
  } cap_entry_t;

  // Flatten an entry into the {epoch, count} word seen by the consumer.
  function automatic logic [EPOCH_W+DATA_W-1:0] packSnapshot(input cap_entry_t e);
    return {e.epoch, e.count};
  endfunction

endpackage

// File: rtl/count_capture_fifo_if.sv
// count_capture_fifo_if
// Valid/ready drain port of the capture FIFO.
//   cap_valid_o : FIFO head holds a snapshot (driven by the FIFO)
//   cap_ready_i : consumer accepts the head this cycle (driven by the consumer)
//   cap_data_o  : head entry {epoch, count}
//   cap_ts_o    : head entry timestamp (only with COUNT_CAPTURE_TS_EN)
// The master modport is the FIFO side, the slave modport the consumer side.
interface count_capture_fifo_if;
  import count_capture_pkg::*;

  logic                      cap_valid_o;
  logic                      cap_ready_i;
  logic [EPOCH_W+DATA_W-1:0] cap_data_o;
`ifdef COUNT_CAPTURE_TS_EN
  logic [TS_W-1:0]           cap_ts_o;

  modport master (output cap_valid_o, output cap_data_o, output cap_ts_o, input cap_ready_i);
  modport slave  (input cap_valid_o, input cap_data_o, input cap_ts_o, output cap_ready_i);
`else
  modport master (output cap_valid_o, output cap_data_o, input cap_ready_i);
  modport slave  (input cap_valid_o, input cap_data_o, output cap_ready_i);
`endif

endinterface

// File: rtl/count_wrap_detector.sv
// count_wrap_detector
// Watches the live counter value and keeps a signed epoch that tracks
// wrap-arounds (MAX->0 increments, 0->MAX decrements). Other jumps are
// ignored. The comparison only starts once one sample has been registered
// after reset, so the reset value of the previous-count register can never
// fake a wrap.
//   clock, reset  : system clock, asynchronous active-high reset
//   i_count       : live counter value
//   o_epochNext   : epoch including any wrap seen on i_count this cycle
//   o_wrap        : registered one-cycle pulse following a detected wrap
module count_wrap_detector
  import count_capture_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic [DATA_W-1:0]  i_count,
  output logic [EPOCH_W-1:0] o_epochNext,
  output logic               o_wrap
);

  logic [DATA_W-1:0]  r_prevCount;
  logic               r_prevValid;
  logic [EPOCH_W-1:0] r_epoch;
  logic               r_wrap;
  logic               w_upWrap;
  logic               w_downWrap;

  assign w_upWrap   = r_prevValid && (r_prevCount == MAX_COUNT) && (i_count == '0);
  assign w_downWrap = r_prevValid && (r_prevCount == '0) && (i_count == MAX_COUNT);

  // Next epoch is combinational so a capture in the same cycle as a wrap
  // already sees the updated epoch. Overflow wraps modulo 2^EPOCH_W.
  always_comb begin
    o_epochNext = r_epoch;
    if (w_upWrap) begin
      o_epochNext = r_epoch + EPOCH_W'(1);
    end else if (w_downWrap) begin
      o_epochNext = r_epoch - EPOCH_W'(1);
    end
  end

  // History, epoch and the wrap pulse all advance every clock.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_prevCount <= '0;
      r_prevValid <= 1'b0;
      r_epoch     <= '0;
      r_wrap      <= 1'b0;
    end else begin
      r_prevCount <= i_count;
      r_prevValid <= 1'b1;
      r_epoch     <= o_epochNext;
      r_wrap      <= w_upWrap || w_downWrap;
    end
  end

  assign o_wrap = r_wrap;

endmodule

// File: rtl/count_capture_fifo.sv
// count_capture_fifo
// Snapshots {epoch, count} of an upstream up/down counter into a small
// ring-buffer FIFO on each capture strobe; a consumer drains it through a
// valid/ready handshake. Captures arriving while full (and no pop) are
// dropped and counted in a saturating 8-bit counter.
//   clock, reset : system clock, asynchronous active-high reset
//   count_i      : live counter value
//   capture_i    : snapshot request
//   cap          : drain port (valid / ready / data [/ ts])
//   level_o      : current FIFO occupancy (0..DEPTH)
//   drop_cnt_o   : captures lost while full, saturating at 255
//   wrap_o       : one-cycle pulse after a wrap was seen on count_i
// Optional build macro: COUNT_CAPTURE_TS_EN adds a free-running 16-bit
// cycle counter whose value at push time is stored with each entry and
// presented on cap.cap_ts_o.
module count_capture_fifo
  import count_capture_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        count_i,
  input  logic                     capture_i,
  count_capture_fifo_if.master     cap,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [7:0]               drop_cnt_o,
  output logic                     wrap_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]      r_wrPtr;
  logic [PW-1:0]      r_rdPtr;
  cap_entry_t         r_mem [DEPTH];
  logic [7:0]         r_dropCnt;
  logic [PW-1:0]      w_level;
  logic               w_valid;
  logic               w_full;
  logic               w_pop;
  logic               w_push;
  logic               w_drop;
  logic [EPOCH_W-1:0] w_epochNext;
  cap_entry_t         w_newEntry;
  cap_entry_t         w_head;

  count_wrap_detector u_wrapDetector (
    .clock       (clock),
    .reset       (reset),
    .i_count     (count_i),
    .o_epochNext (w_epochNext),
    .o_wrap      (wrap_o)
  );

  // Pointers carry one extra bit so full and empty are distinguishable;
  // their difference is the occupancy directly.
  assign w_level = r_wrPtr - r_rdPtr;
  assign w_valid = (w_level != '0);
  assign w_full  = (w_level == PW'(DEPTH));
  // Pop requires a valid head, so an empty FIFO never falls through.
  assign w_pop   = w_valid && cap.cap_ready_i;
  assign w_push  = capture_i && (!w_full || w_pop);
  assign w_drop  = capture_i && w_full && !w_pop;

`ifdef COUNT_CAPTURE_TS_EN
  logic [TS_W-1:0] r_tsCnt;

  // Free-running timestamp; wraps silently.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tsCnt <= '0;
    end else begin
      r_tsCnt <= r_tsCnt + TS_W'(1);
    end
  end
`else
  // Default build: no timestamp counter.
`endif

  // Build the entry to be pushed from the epoch that already includes any
  // wrap happening in this same cycle.
  always_comb begin
    w_newEntry       = '0;
    w_newEntry.epoch = $signed(w_epochNext);
    w_newEntry.count = count_i;
`ifdef COUNT_CAPTURE_TS_EN
    w_newEntry.ts    = r_tsCnt;
`endif
  end

  // Storage is cleared on reset so the head data reads as zero out of reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wrPtr[AW-1:0]] <= w_newEntry;
    end
  end

  // Read/write pointers move independently; push and pop in the same cycle
  // leave the level unchanged.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PW'(1);
      end
    end
  end

  // Lost-capture counter sticks at 255 until the next reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_dropCnt <= '0;
    end else if (w_drop && (r_dropCnt != 8'hFF)) begin
      r_dropCnt <= r_dropCnt + 8'd1;
    end
  end

  // Head data is a plain read of the slot under the read pointer; after the
  // last pop it keeps showing the stale slot, which is stable.
  assign w_head          = r_mem[r_rdPtr[AW-1:0]];
  assign cap.cap_valid_o = w_valid;
  assign cap.cap_data_o  = packSnapshot(w_head);
`ifdef COUNT_CAPTURE_TS_EN
  assign cap.cap_ts_o    = w_head.ts;
`endif

  assign level_o    = w_level;
  assign drop_cnt_o = r_dropCnt;

endmodule

// File: tb/tb_count_capture_fifo.sv
// tb_count_capture_fifo
// Directed bench for count_capture_fifo (default build, DEPTH=4).
// Inputs change one time unit after a rising edge and outputs are read at
// that same point, well away from the next active edge.
module tb_count_capture_fifo;

  logic       clock;
  logic       reset;
  logic [7:0] count_i;
  logic       capture_i;
  logic [2:0] level_o;
  logic [7:0] drop_cnt_o;
  logic       wrap_o;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;
  int wrapSeen   = 0;

  count_capture_fifo_if capIf ();

  count_capture_fifo #(.DEPTH(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .count_i    (count_i),
    .capture_i  (capture_i),
    .cap        (capIf),
    .level_o    (level_o),
    .drop_cnt_o (drop_cnt_o),
    .wrap_o     (wrap_o)
  );

  // 10-unit free-running clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive one cycle of inputs, advance past the next rising edge, and keep
  // a running tally of wrap pulses.
  task automatic applyStimulus(input logic [7:0] c, input logic cap, input logic rdy);
    count_i           = c;
    capture_i         = cap;
    capIf.cap_ready_i = rdy;
    @(posedge clock);
    #1;
    if (wrap_o) wrapSeen++;
  endtask

  // One comparison point.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Asynchronous reset pulse that does not straddle a clock edge.
  task automatic pulseReset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  initial begin
    logic [11:0] drainExp [4];
    drainExp = '{12'h00B, 12'h00C, 12'h00D, 12'h010};

    reset             = 1'b1;
    count_i           = 8'd0;
    capture_i         = 1'b0;
    capIf.cap_ready_i = 1'b0;

    // Reset values, observed before any clock edge.
    #3;
    checkOutput("rst_valid", capIf.cap_valid_o, 0);
    checkOutput("rst_data",  capIf.cap_data_o, 0);
    checkOutput("rst_level", level_o, 0);
    checkOutput("rst_drop",  drop_cnt_o, 0);
    checkOutput("rst_wrap",  wrap_o, 0);
    #1;
    reset = 1'b0;

    // Up sweep 0..255 then across the top into 0,1, capture at 2.
    $display("[TB] up-wrap sweep");
    wrapSeen = 0;
    for (int v = 0; v <= 255; v++) applyStimulus(8'(v), 1'b0, 1'b0);
    checkOutput("sweep_no_wrap", wrapSeen, 0);
    applyStimulus(8'd0, 1'b0, 1'b0);
    checkOutput("up_wrap_pulse", wrap_o, 1);
    applyStimulus(8'd1, 1'b0, 1'b0);
    checkOutput("up_wrap_end", wrap_o, 0);
    applyStimulus(8'd2, 1'b1, 1'b0);
    checkOutput("up_cap_valid", capIf.cap_valid_o, 1);
    checkOutput("up_cap_data",  capIf.cap_data_o, 12'h102);
    checkOutput("up_cap_level", level_o, 1);
    applyStimulus(8'd3, 1'b0, 1'b0);
    checkOutput("up_wrap_once", wrapSeen, 1);
    applyStimulus(8'd3, 1'b0, 1'b1);
    checkOutput("up_pop_level", level_o, 0);
    checkOutput("up_pop_valid", capIf.cap_valid_o, 0);

    // Down wrap from a fresh epoch of zero.
    $display("[TB] down-wrap");
    pulseReset();
    applyStimulus(8'd1, 1'b0, 1'b0);
    applyStimulus(8'd0, 1'b0, 1'b0);
    applyStimulus(8'd255, 1'b0, 1'b0);
    checkOutput("down_wrap_pulse", wrap_o, 1);
    applyStimulus(8'd254, 1'b1, 1'b0);
    checkOutput("down_cap_data", capIf.cap_data_o, 12'hFFE);
    checkOutput("down_wrap_end", wrap_o, 0);
    applyStimulus(8'd254, 1'b0, 1'b1);
    checkOutput("down_pop_level", level_o, 0);

    // The first sample after reset only primes the history.
    $display("[TB] prev_valid qualification");
    pulseReset();
    applyStimulus(8'd0, 1'b0, 1'b0);
    checkOutput("prime_no_wrap", wrap_o, 0);
    applyStimulus(8'd255, 1'b0, 1'b0);
    checkOutput("primed_down_wrap", wrap_o, 1);
    pulseReset();
    applyStimulus(8'd255, 1'b1, 1'b0);
    checkOutput("direct_255_no_wrap", wrap_o, 0);
    checkOutput("direct_255_data", capIf.cap_data_o, 12'h0FF);
    applyStimulus(8'd255, 1'b0, 1'b1);

    // Six captures into a 4-deep FIFO with no consumer.
    $display("[TB] overflow");
    pulseReset();
    for (int v = 10; v <= 15; v++) applyStimulus(8'(v), 1'b1, 1'b0);
    checkOutput("ovf_level", level_o, 4);
    checkOutput("ovf_drop",  drop_cnt_o, 2);
    checkOutput("ovf_head",  capIf.cap_data_o, 12'h00A);

    // Full with push and pop together: both happen, no drop.
    applyStimulus(8'd16, 1'b1, 1'b1);
    checkOutput("fullpp_level", level_o, 4);
    checkOutput("fullpp_drop",  drop_cnt_o, 2);
    checkOutput("fullpp_head",  capIf.cap_data_o, 12'h00B);
    applyStimulus(8'd16, 1'b0, 1'b0);
    checkOutput("hold_valid", capIf.cap_valid_o, 1);
    checkOutput("hold_head",  capIf.cap_data_o, 12'h00B);

    // Drain in push order.
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("drain_valid_%0d", i), capIf.cap_valid_o, 1);
      checkOutput($sformatf("drain_head_%0d", i), capIf.cap_data_o, 32'(drainExp[i]));
      applyStimulus(8'd16, 1'b0, 1'b1);
    end
    checkOutput("drained_level", level_o, 0);
    checkOutput("drained_valid", capIf.cap_valid_o, 0);

    // Empty with push and ready together: push only, no fall-through.
    applyStimulus(8'd20, 1'b1, 1'b1);
    checkOutput("emptypp_level", level_o, 1);
    checkOutput("emptypp_data",  capIf.cap_data_o, 12'h014);
    applyStimulus(8'd20, 1'b0, 1'b1);
    checkOutput("emptypp_pop", level_o, 0);

    // Build epoch 2 and three entries, then reset without a clock edge.
    $display("[TB] mid-operation reset");
    applyStimulus(8'd255, 1'b0, 1'b0);
    applyStimulus(8'd0, 1'b0, 1'b0);
    applyStimulus(8'd254, 1'b0, 1'b0);
    applyStimulus(8'd255, 1'b0, 1'b0);
    applyStimulus(8'd0, 1'b0, 1'b0);
    applyStimulus(8'd1, 1'b1, 1'b0);
    applyStimulus(8'd2, 1'b1, 1'b0);
    applyStimulus(8'd3, 1'b1, 1'b0);
    checkOutput("pre_rst_level", level_o, 3);
    checkOutput("pre_rst_head",  capIf.cap_data_o, 12'h201);
    checkOutput("pre_rst_drop",  drop_cnt_o, 2);
    reset = 1'b1;
    #1;
    checkOutput("async_rst_valid", capIf.cap_valid_o, 0);
    checkOutput("async_rst_level", level_o, 0);
    checkOutput("async_rst_drop",  drop_cnt_o, 0);
    #1;
    reset = 1'b0;
    applyStimulus(8'd5, 1'b1, 1'b0);
    checkOutput("post_rst_epoch0", capIf.cap_data_o, 12'h005);

    // Drop counter saturation.
    $display("[TB] drop saturation");
    for (int v = 6; v <= 8; v++) applyStimulus(8'(v), 1'b1, 1'b0);
    checkOutput("sat_full", level_o, 4);
    for (int i = 0; i < 256; i++) applyStimulus(8'd9, 1'b1, 1'b0);
    checkOutput("sat_drop",  drop_cnt_o, 255);
    checkOutput("sat_level", level_o, 4);
    checkOutput("sat_head",  capIf.cap_data_o, 12'h005);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/count_capture_fifo.md
Name: count_capture_fifo

Overview:
Downstream consumer of the 8-bit up/down counter output. It watches the counter value every cycle and tracks wrap-arounds (255->0 and 0->255) in a signed epoch register. On a capture strobe it pushes an {epoch, count} snapshot into a small FIFO. Software or a downstream stage drains the FIFO through a valid/ready handshake.

Parameters:
DATA_W, 8, width of monitored counter value
EPOCH_W, 4, width of signed two's-complement wrap epoch
DEPTH, 4, FIFO entries (power of two, >=2)

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
count_i  input  DATA_W  live counter value from upstream counter
capture_i  input  1  snapshot request, sampled on rising clock
cap_valid_o  output  1  FIFO head holds a snapshot
cap_ready_i  input  1  consumer accepts head this cycle
cap_data_o  output  EPOCH_W+DATA_W  head entry {epoch, count}
level_o  output  $clog2(DEPTH)+1  current FIFO occupancy
drop_cnt_o  output  8  captures lost while full, saturating
wrap_o  output  1  pulse: wrap detected this cycle (either direction)

Behaviour:
- reset is asynchronous, active-high; clock is clock. Reset values: cap_valid_o=0, cap_data_o=0, level_o=0, drop_cnt_o=0, wrap_o=0, epoch=0, prev_valid=0.
- Wrap detection: prev_count is registered each cycle. prev_valid is set on the first clock after reset.
  - Only when prev_valid=1: prev==MAX && count_i==0 -> epoch+1 (up wrap); prev==0 && count_i==MAX -> epoch-1 (down wrap).
  - Any other change, including jumps, does not affect epoch.
- epoch wraps modulo 2^EPOCH_W (7+1 -> -8). No saturation.
- wrap_o is registered: high for one cycle, the cycle after the wrap is seen on count_i.
- Capture entry is {epoch_next, count_i}, where epoch_next already includes any wrap detected in the same cycle.
- Push happens when capture_i=1 and (level<DEPTH or pop this cycle). Pop happens when cap_valid_o && cap_ready_i.
- Simultaneous push and pop when full: both occur, level unchanged.
- Simultaneous push and pop when empty: push only. There is no fall-through; the pop condition is false.
- Latency: capture at edge N gives cap_valid_o=1 after edge N (visible in cycle N+1).
- cap_data_o always reflects the head entry. Its value when cap_valid_o=0 is don't-care but stable.
- Capture while full with no pop: entry discarded, drop_cnt_o increments and saturates at 255. It is cleared only by reset.
- cap_valid_o may not deassert without a pop. Head data stays stable while valid && !ready.
- Reset mid-operation flushes the FIFO immediately and zeroes epoch and the drop counter.

Optional Feature:
COUNT_CAPTURE_TS_EN
- Defined: a 16-bit free-running cycle counter (reset 0, wraps) is added. Each entry also stores the timestamp at push time, on an extra output port cap_ts_o[15:0] that is aligned with cap_data_o.
- Undefined: no timestamp counter, no cap_ts_o port, no storage cost.

Decomposition:
- Package count_capture_pkg holds:
  - DATA_W and EPOCH_W defaults
  - typedef cap_entry_t (packed struct: epoch signed [EPOCH_W-1:0], count [DATA_W-1:0], plus ts [15:0] under the macro)
  - MAX_COUNT constant
- One sub-module, count_wrap_detector: prev_count/prev_valid registers, up/down wrap decode, epoch register, wrap_o.
- The FIFO (ring buffer, rd/wr pointers with an extra wrap bit) stays inline in count_capture_fifo.

Test Plan:
- Reset, then count_i up 0..255..0..3, capture at count 2 after the wrap -> cap_data_o={epoch=1,count=2}; wrap_o pulses once.
- count_i steps 1,0,255,254, capture at 254 -> entry {epoch=-1 (4'hF), count=254}.
- First cycle after reset count_i=0 while the internal prev_count=0 reset value is not yet valid; next count_i=255 -> counts as a down wrap only because prev_valid is set. A direct reset-release with count_i=255 gives no wrap.
- cap_ready_i=0, capture 6 consecutive cycles with DEPTH=4 -> level_o=4, drop_cnt_o=2; then drain -> 4 entries in push order.
- FIFO full, capture_i=1 and cap_ready_i=1 same cycle -> head popped, new entry appended, level_o stays 4, drop_cnt_o unchanged.
- Assert reset while level_o=3 and epoch=2 -> cap_valid_o=0, level_o=0, epoch=0 immediately, with no clock edge required.
